// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32 core: status, trap, interrupt and counter state.
// Decode reads combinationally; writeback drives writes, trap entry, retire and mret.
module csr_file #(
  parameter int          COUNTER_WIDTH = 64,
  parameter int          NUM_LOCAL_IRQ = 1,
  parameter int          VECTORED_EN   = 1,
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [11:0]              read_address,
  output logic [31:0]              read_data,
  output logic                     readable,
  output logic                     writeable,
  input  logic                     write_enable,
  input  logic [11:0]              write_address,
  input  logic [31:0]              write_data,
  input  logic                     retired,
  input  logic                     traped,
  input  logic                     mret,
  input  logic [31:0]              ecp,
  input  logic [31:0]              trap_cause,
  input  logic [31:0]              trap_value,
  input  logic                     ext_irq,
  input  logic                     timer_irq,
  input  logic                     soft_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
  output logic                     eip,
  output logic                     tip,
  output logic                     sip,
  output logic                     lip,
  output logic [31:0]              trap_vector,
  output logic [31:0]              mret_vector
);

  localparam logic [31:0] LOCAL_MASK = ((32'h0000_0001 << NUM_LOCAL_IRQ) - 32'h0000_0001) << 16;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic                     mstatus_mie_r;
  logic                     mstatus_mpie_r;
  logic [31:0]              mie_r;
  logic [31:0]              mip_r;
  logic [29:0]              mtvec_base_r;
  logic                     mtvec_mode_r;
  logic [31:0]              mscratch_r;
  logic [31:0]              mepc_r;
  logic [31:0]              mcause_r;
  logic [31:0]              mtval_r;
  logic [COUNTER_WIDTH-1:0] mcycle_r;
  logic [COUNTER_WIDTH-1:0] minstret_r;

  logic        wr_en_s;
  logic [31:0] mip_in_s;
  logic [31:0] mstatus_s;
  logic [63:0] mcycle_ext_s;
  logic [63:0] minstret_ext_s;
  logic [31:0] rd_data_s;
  logic        rd_ok_s;
  logic [31:0] tvec_base_s;

  // Low-half write replaces bits[31:0]; high-half write replaces the upper bits; a write suppresses the increment.
  function automatic logic [COUNTER_WIDTH-1:0] cnt_next(
    input logic [COUNTER_WIDTH-1:0] cur,
    input logic                     inc,
    input logic                     wr_lo,
    input logic                     wr_hi,
    input logic [31:0]              wd
  );
    logic [63:0] wide;
    wide = 64'(cur);
    if (wr_lo) begin
      wide[31:0] = wd;
      cnt_next = wide[COUNTER_WIDTH-1:0];
    end else if (wr_hi && (COUNTER_WIDTH > 32)) begin
      wide[63:32] = wd;
      cnt_next = wide[COUNTER_WIDTH-1:0];
    end else if (inc) begin
      cnt_next = cur + CNT_ONE;
    end else begin
      cnt_next = cur;
    end
  endfunction

  // A trap or mret in the same cycle squashes the writeback CSR write.
  assign wr_en_s = write_enable & ~traped & ~mret;

  // Assemble the raw interrupt levels into mip bit positions.
  always_comb begin
    mip_in_s                       = 32'h0000_0000;
    mip_in_s[3]                    = soft_irq;
    mip_in_s[7]                    = timer_irq;
    mip_in_s[11]                   = ext_irq;
    mip_in_s[16 +: NUM_LOCAL_IRQ]  = local_irq;
  end

  // mstatus view: MPP hardwired to machine mode.
  always_comb begin
    mstatus_s        = 32'h0000_0000;
    mstatus_s[12:11] = 2'b11;
    mstatus_s[7]     = mstatus_mpie_r;
    mstatus_s[3]     = mstatus_mie_r;
  end

  assign mcycle_ext_s   = 64'(mcycle_r);
  assign minstret_ext_s = 64'(minstret_r);

  // Combinational read mux for decode.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_ok_s   = 1'b1;
    case (read_address)
      12'h300: rd_data_s = mstatus_s;
      12'h301: rd_data_s = 32'h4000_0100;
      12'h304: rd_data_s = mie_r;
      12'h305: rd_data_s = {mtvec_base_r, 1'b0, mtvec_mode_r};
      12'h340: rd_data_s = mscratch_r;
      12'h341: rd_data_s = mepc_r;
      12'h342: rd_data_s = mcause_r;
      12'h343: rd_data_s = mtval_r;
      12'h344: rd_data_s = mip_r;
      12'hB00, 12'hC00: rd_data_s = mcycle_ext_s[31:0];
      12'hB80, 12'hC80: rd_data_s = mcycle_ext_s[63:32];
      12'hB02, 12'hC02: rd_data_s = minstret_ext_s[31:0];
      12'hB82, 12'hC82: rd_data_s = minstret_ext_s[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: rd_data_s = 32'h0000_0000;
      default: begin
        rd_data_s = 32'h0000_0000;
        rd_ok_s   = 1'b0;
      end
    endcase
  end

  assign read_data = rd_data_s;
  assign readable  = rd_ok_s;
  assign writeable = rd_ok_s & (read_address[11:10] != 2'b11);

  assign tvec_base_s = {mtvec_base_r, 2'b00};
  assign trap_vector = (mtvec_mode_r && trap_cause[31])
                       ? tvec_base_s + {25'd0, trap_cause[4:0], 2'b00}
                       : tvec_base_s;
  assign mret_vector = mepc_r;

  assign eip = mip_r[11] & mie_r[11] & mstatus_mie_r;
  assign tip = mip_r[7]  & mie_r[7]  & mstatus_mie_r;
  assign sip = mip_r[3]  & mie_r[3]  & mstatus_mie_r;
  assign lip = (|(mip_r & mie_r & LOCAL_MASK)) & mstatus_mie_r;

  // mstatus interrupt-enable stack: trap pushes, mret pops, else software write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
    end else if (traped) begin
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (mret) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (wr_en_s && (write_address == 12'h300)) begin
      mstatus_mie_r  <= write_data[3];
      mstatus_mpie_r <= write_data[7];
    end
  end

  // Trap record registers: trap entry overrides any concurrent write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mepc_r   <= 32'h0000_0000;
      mcause_r <= 32'h0000_0000;
      mtval_r  <= 32'h0000_0000;
    end else if (traped) begin
      mepc_r   <= ecp & 32'hFFFF_FFFC;
      mcause_r <= trap_cause;
      mtval_r  <= trap_value;
    end else if (wr_en_s) begin
      if (write_address == 12'h341) mepc_r   <= write_data & 32'hFFFF_FFFC;
      if (write_address == 12'h342) mcause_r <= write_data;
      if (write_address == 12'h343) mtval_r  <= write_data;
    end
  end

  // Plain configuration registers: mie, mtvec (WARL mode), mscratch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mie_r        <= 32'h0000_0000;
      mtvec_base_r <= RESET_VECTOR[31:2];
      mtvec_mode_r <= 1'b0;
      mscratch_r   <= 32'h0000_0000;
    end else if (wr_en_s) begin
      if (write_address == 12'h304) mie_r      <= write_data & MIE_MASK;
      if (write_address == 12'h340) mscratch_r <= write_data;
      if (write_address == 12'h305) begin
        mtvec_base_r <= write_data[31:2];
        case (write_data[1:0])
          2'b00:   mtvec_mode_r <= 1'b0;
          2'b01:   mtvec_mode_r <= (VECTORED_EN != 0);
          default: mtvec_mode_r <= mtvec_mode_r;
        endcase
      end
    end
  end

  // Interrupt sampling and free-running counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mip_r      <= 32'h0000_0000;
      mcycle_r   <= '0;
      minstret_r <= '0;
    end else begin
      mip_r      <= mip_in_s;
      mcycle_r   <= cnt_next(mcycle_r, 1'b1,
                             wr_en_s && (write_address == 12'hB00),
                             wr_en_s && (write_address == 12'hB80), write_data);
      minstret_r <= cnt_next(minstret_r, retired,
                             wr_en_s && (write_address == 12'hB02),
                             wr_en_s && (write_address == 12'hB82), write_data);
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: a 64-bit vectored instance and a
// 40-bit non-vectored instance driven from the same writeback stimulus.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] read_address = 12'h000;
  logic        write_enable = 1'b0;
  logic [11:0] write_address = 12'h000;
  logic [31:0] write_data = 32'h0;
  logic        retired = 1'b0, traped = 1'b0, mret = 1'b0;
  logic [31:0] ecp = 32'h0, trap_cause = 32'h0, trap_value = 32'h0;
  logic        ext_irq = 1'b0, timer_irq = 1'b0, soft_irq = 1'b0;
  logic [0:0]  local_irq = 1'b0;
  logic [1:0]  local_irq_b = 2'b00;

  logic [31:0] read_data, trap_vector, mret_vector;
  logic        readable, writeable, eip, tip, sip, lip;
  logic [31:0] read_data_b, trap_vector_b, mret_vector_b;
  logic        readable_b, writeable_b, eip_b, tip_b, sip_b, lip_b;

  int vecs = 0;
  int errs = 0;

  always #10 clk = ~clk;

  csr_file #(.COUNTER_WIDTH(64), .NUM_LOCAL_IRQ(1), .VECTORED_EN(1),
             .RESET_VECTOR(32'h0000_0400)) u_dut (
    .clk(clk), .reset_n(reset_n), .read_address(read_address), .read_data(read_data),
    .readable(readable), .writeable(writeable), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data), .retired(retired),
    .traped(traped), .mret(mret), .ecp(ecp), .trap_cause(trap_cause),
    .trap_value(trap_value), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .soft_irq(soft_irq), .local_irq(local_irq), .eip(eip), .tip(tip), .sip(sip),
    .lip(lip), .trap_vector(trap_vector), .mret_vector(mret_vector));

  csr_file #(.COUNTER_WIDTH(40), .NUM_LOCAL_IRQ(2), .VECTORED_EN(0),
             .RESET_VECTOR(32'h0000_0000)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .read_address(read_address), .read_data(read_data_b),
    .readable(readable_b), .writeable(writeable_b), .write_enable(write_enable),
    .write_address(write_address), .write_data(write_data), .retired(retired),
    .traped(traped), .mret(mret), .ecp(ecp), .trap_cause(trap_cause),
    .trap_value(trap_value), .ext_irq(ext_irq), .timer_irq(timer_irq),
    .soft_irq(soft_irq), .local_irq(local_irq_b), .eip(eip_b), .tip(tip_b), .sip(sip_b),
    .lip(lip_b), .trap_vector(trap_vector_b), .mret_vector(mret_vector_b));

  // Select a read address and let the combinational read settle.
  task automatic rd(input logic [11:0] a);
    read_address = a;
    #1;
  endtask

  // One-cycle CSR write; call in the low phase, returns at the next negedge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    write_enable = 1'b1; write_address = a; write_data = d;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vecs++; if (trap_vector !== 32'h0000_0400) begin errs++; $display("FAIL rst_trap_vector got %h exp %h", trap_vector, 32'h0000_0400); end
    vecs++; if (mret_vector !== 32'h0) begin errs++; $display("FAIL rst_mret_vector got %h exp %h", mret_vector, 32'h0); end
    vecs++; if ({eip, tip, sip, lip} !== 4'b0000) begin errs++; $display("FAIL rst_irq_outs got %b exp %b", {eip, tip, sip, lip}, 4'b0000); end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    rd(12'hB00);
    vecs++; if (read_data !== 32'd10) begin errs++; $display("FAIL rst_mcycle got %h exp %h", read_data, 32'd10); end
    rd(12'hB02);
    vecs++; if (read_data !== 32'd0) begin errs++; $display("FAIL rst_minstret got %h exp %h", read_data, 32'd0); end
    rd(12'h305);
    vecs++; if (read_data !== 32'h0000_0400) begin errs++; $display("FAIL rst_mtvec got %h exp %h", read_data, 32'h0000_0400); end
    rd(12'h7C0);
    vecs++; if ({readable, read_data} !== {1'b0, 32'h0}) begin errs++; $display("FAIL rst_unimpl got %b/%h exp 0/0", readable, read_data); end
    @(negedge clk);
    reset_n = 1'b0;
    rd(12'hB00);
    vecs++; if (read_data !== 32'd0) begin errs++; $display("FAIL midreset_mcycle got %h exp %h", read_data, 32'd0); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_counter_wrap;
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0000_0000);
    rd(12'hB00);
    vecs++; if (read_data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL wrap_lo_pre got %h exp %h", read_data, 32'hFFFF_FFFF); end
    @(negedge clk);
    rd(12'hB80);
    vecs++; if (read_data !== 32'h1) begin errs++; $display("FAIL wrap_hi got %h exp %h", read_data, 32'h1); end
    vecs++; if (read_data_b !== 32'h1) begin errs++; $display("FAIL wrap_hi_w40 got %h exp %h", read_data_b, 32'h1); end
    rd(12'hB00);
    vecs++; if (read_data !== 32'h0) begin errs++; $display("FAIL wrap_lo got %h exp %h", read_data, 32'h0); end
    rd(12'hC80);
    vecs++; if (read_data !== 32'h1) begin errs++; $display("FAIL wrap_cycleh got %h exp %h", read_data, 32'h1); end
    wr(12'hB80, 32'h0000_00FF);
    wr(12'hB00, 32'hFFFF_FFFE);
    rd(12'hB80);
    vecs++; if (read_data_b !== 32'hFF) begin errs++; $display("FAIL w40_hi_pre got %h exp %h", read_data_b, 32'hFF); end
    @(negedge clk);
    @(negedge clk);
    rd(12'hB80);
    vecs++; if (read_data_b !== 32'h0) begin errs++; $display("FAIL w40_wrap_hi got %h exp %h", read_data_b, 32'h0); end
    vecs++; if (read_data !== 32'h100) begin errs++; $display("FAIL w64_carry_hi got %h exp %h", read_data, 32'h100); end
    rd(12'hB00);
    vecs++; if (read_data_b !== 32'h0) begin errs++; $display("FAIL w40_wrap_lo got %h exp %h", read_data_b, 32'h0); end
    wr(12'hB80, 32'h1234_5678);
    rd(12'hB80);
    vecs++; if (read_data_b !== 32'h78) begin errs++; $display("FAIL w40_hi_trunc got %h exp %h", read_data_b, 32'h78); end
  endtask

  task automatic test_write_priority;
    retired = 1'b1;
    wr(12'hB02, 32'd5);
    retired = 1'b0;
    rd(12'hB02);
    vecs++; if (read_data !== 32'd5) begin errs++; $display("FAIL wr_beats_retire got %h exp %h", read_data, 32'd5); end
    retired = 1'b1;
    repeat (3) @(negedge clk);
    retired = 1'b0;
    rd(12'hC02);
    vecs++; if (read_data !== 32'd8) begin errs++; $display("FAIL instret_count got %h exp %h", read_data, 32'd8); end
    rd(12'hC00);
    vecs++; if (writeable !== 1'b0) begin errs++; $display("FAIL writeable_c00 got %b exp %b", writeable, 1'b0); end
    rd(12'hB00);
    vecs++; if (writeable !== 1'b1) begin errs++; $display("FAIL writeable_b00 got %b exp %b", writeable, 1'b1); end
  endtask

  task automatic test_trap_mret;
    wr(12'h300, 32'h8);
    rd(12'h300);
    vecs++; if (read_data !== 32'h1808) begin errs++; $display("FAIL mstatus_wr got %h exp %h", read_data, 32'h1808); end
    wr(12'h340, 32'h11);
    traped = 1'b1; ecp = 32'h103; trap_cause = 32'h2; trap_value = 32'hDEAD;
    wr(12'h340, 32'h55);
    traped = 1'b0;
    rd(12'h341);
    vecs++; if (read_data !== 32'h100) begin errs++; $display("FAIL trap_mepc got %h exp %h", read_data, 32'h100); end
    rd(12'h342);
    vecs++; if (read_data !== 32'h2) begin errs++; $display("FAIL trap_mcause got %h exp %h", read_data, 32'h2); end
    rd(12'h343);
    vecs++; if (read_data !== 32'hDEAD) begin errs++; $display("FAIL trap_mtval got %h exp %h", read_data, 32'hDEAD); end
    rd(12'h300);
    vecs++; if (read_data !== 32'h1880) begin errs++; $display("FAIL trap_mstatus got %h exp %h", read_data, 32'h1880); end
    rd(12'h340);
    vecs++; if (read_data !== 32'h11) begin errs++; $display("FAIL trap_drops_write got %h exp %h", read_data, 32'h11); end
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    rd(12'h300);
    vecs++; if (read_data !== 32'h1888) begin errs++; $display("FAIL mret_mstatus got %h exp %h", read_data, 32'h1888); end
    vecs++; if (mret_vector !== 32'h100) begin errs++; $display("FAIL mret_vector got %h exp %h", mret_vector, 32'h100); end
    wr(12'h341, 32'h207);
    vecs++; if (mret_vector !== 32'h204) begin errs++; $display("FAIL mepc_wr_align got %h exp %h", mret_vector, 32'h204); end
  endtask

  task automatic test_vectored;
    wr(12'h305, 32'h1001);
    trap_cause = 32'h8000_0007;
    rd(12'h305);
    vecs++; if (read_data !== 32'h1001) begin errs++; $display("FAIL mtvec_vec got %h exp %h", read_data, 32'h1001); end
    vecs++; if (trap_vector !== 32'h101C) begin errs++; $display("FAIL tvec_irq got %h exp %h", trap_vector, 32'h101C); end
    vecs++; if (read_data_b !== 32'h1000) begin errs++; $display("FAIL mtvec_novec got %h exp %h", read_data_b, 32'h1000); end
    trap_cause = 32'h2;
    #1;
    vecs++; if (trap_vector !== 32'h1000) begin errs++; $display("FAIL tvec_exc got %h exp %h", trap_vector, 32'h1000); end
    wr(12'h305, 32'h2003);
    trap_cause = 32'h8000_0003;
    rd(12'h305);
    vecs++; if (read_data !== 32'h2001) begin errs++; $display("FAIL mtvec_mode_keep got %h exp %h", read_data, 32'h2001); end
    vecs++; if (trap_vector !== 32'h200C) begin errs++; $display("FAIL tvec_irq3 got %h exp %h", trap_vector, 32'h200C); end
    vecs++; if (trap_vector_b !== 32'h2000) begin errs++; $display("FAIL tvec_novec got %h exp %h", trap_vector_b, 32'h2000); end
    trap_cause = 32'h0;
  endtask

  task automatic test_interrupts;
    wr(12'h304, 32'h0001_0880);
    wr(12'h300, 32'h8);
    rd(12'h304);
    vecs++; if (read_data !== 32'h0001_0880) begin errs++; $display("FAIL mie_rd got %h exp %h", read_data, 32'h0001_0880); end
    timer_irq = 1'b1;
    #1;
    vecs++; if (tip !== 1'b0) begin errs++; $display("FAIL tip_latency got %b exp %b", tip, 1'b0); end
    @(negedge clk);
    vecs++; if (tip !== 1'b1) begin errs++; $display("FAIL tip_set got %b exp %b", tip, 1'b1); end
    local_irq = 1'b1; soft_irq = 1'b1;
    @(negedge clk);
    vecs++; if (lip !== 1'b1) begin errs++; $display("FAIL lip_set got %b exp %b", lip, 1'b1); end
    vecs++; if ({eip, sip} !== 2'b00) begin errs++; $display("FAIL eip_sip_idle got %b exp %b", {eip, sip}, 2'b00); end
    rd(12'h344);
    vecs++; if (read_data !== 32'h0001_0088) begin errs++; $display("FAIL mip_rd got %h exp %h", read_data, 32'h0001_0088); end
    ext_irq = 1'b1;
    @(negedge clk);
    vecs++; if (eip !== 1'b1) begin errs++; $display("FAIL eip_set got %b exp %b", eip, 1'b1); end
    wr(12'h300, 32'h0);
    vecs++; if ({eip, tip, lip} !== 3'b000) begin errs++; $display("FAIL mie_clear got %b exp %b", {eip, tip, lip}, 3'b000); end
    wr(12'h304, 32'hFFFF_FFFF);
    rd(12'h304);
    vecs++; if (read_data !== 32'h0001_0888) begin errs++; $display("FAIL mie_mask got %h exp %h", read_data, 32'h0001_0888); end
    vecs++; if (read_data_b !== 32'h0003_0888) begin errs++; $display("FAIL mie_mask_b got %h exp %h", read_data_b, 32'h0003_0888); end
    ext_irq = 1'b0; timer_irq = 1'b0; soft_irq = 1'b0; local_irq = 1'b0;
  endtask

  task automatic test_misc_regs;
    rd(12'h301);
    vecs++; if (read_data !== 32'h4000_0100) begin errs++; $display("FAIL misa got %h exp %h", read_data, 32'h4000_0100); end
    wr(12'h301, 32'h0);
    rd(12'h301);
    vecs++; if (read_data !== 32'h4000_0100) begin errs++; $display("FAIL misa_ro got %h exp %h", read_data, 32'h4000_0100); end
    rd(12'hF12);
    vecs++; if ({readable, writeable, read_data} !== {2'b10, 32'h0}) begin errs++; $display("FAIL mhartid got %b%b/%h exp 10/0", readable, writeable, read_data); end
    rd(12'h3A0);
    vecs++; if (readable !== 1'b0) begin errs++; $display("FAIL unimpl_3a0 got %b exp %b", readable, 1'b0); end
  endtask

  initial begin
    test_reset;
    test_counter_wrap;
    test_write_priority;
    test_trap_mret;
    test_vectored;
    test_interrupts;
    test_misc_regs;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
